fft_frame_loader: RTL

- Upstream stage of the 128-point butterfly stage.
- Accepts a serial stream of complex 16-bit samples in natural order over a valid/ready handshake.
- Assembles each 128-sample frame in a ping-pong (two-bank) buffer.
- Presents each complete frame as parallel real/complex buses, with a frame_valid/frame_ready handshake, to the butterfly stage.

---
 rtl/fft_frame_loader.sv | 91 +++++++++
 1 files changed

// File: rtl/fft_frame_loader.sv
// Ping-pong frame assembler feeding the 128-point butterfly stage.
// Ports: in_* sample stream (valid/ready), frame_* / *_out parallel frame, wr_count, align_err.
module fft_frame_loader #(
  parameter int DATA_W = 16,
  parameter int N      = 128,
  parameter int PTR_W  = $clog2(N)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_real,
  input  logic [DATA_W-1:0]             in_complex,
  input  logic                          in_last,
  output logic                          frame_valid,
  input  logic                          frame_ready,
  output logic [N-1:0][DATA_W-1:0]      real_out,
  output logic [N-1:0][DATA_W-1:0]      complex_out,
  output logic [PTR_W-1:0]              wr_count,
  output logic                          align_err
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(N - 1);

  logic [DATA_W-1:0] re_mem [2][N];
  logic [DATA_W-1:0] im_mem [2][N];

  logic [1:0]       bank_full;
  logic [1:0]       full_nxt;
  logic             wr_bank;
  logic             rd_bank;
  logic [PTR_W-1:0] wr_ptr;

  logic accept;
  logic consume;
  logic at_last;

  assign in_ready    = !bank_full[wr_bank];
  assign frame_valid = bank_full[rd_bank];
  assign accept      = in_valid && in_ready;
  assign consume     = frame_valid && frame_ready;
  assign at_last     = (wr_ptr == LAST);
  assign wr_count    = wr_ptr;

  // Fill and drain always target different banks, so both
  // updates can land in the same cycle without conflict.
  always_comb begin
    full_nxt = bank_full;
    if (accept && at_last) full_nxt[wr_bank] = 1'b1;
    if (consume)           full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      re_mem[wr_bank][wr_ptr] <= in_real;
      im_mem[wr_bank][wr_ptr] <= in_complex;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_full <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_ptr    <= '0;
      align_err <= 1'b0;
    end else begin
      bank_full <= full_nxt;
      if (accept) begin
        if (at_last) begin
          wr_ptr  <= '0;
          wr_bank <= !wr_bank;
        end else begin
          wr_ptr  <= wr_ptr + 1'b1;
        end
        // in_last is advisory; framing is owned by wr_ptr.
        if (in_last != at_last) align_err <= 1'b1;
      end
      if (consume) rd_bank <= !rd_bank;
    end
  end

  // Zero the bus when no frame is presented.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      real_out[i]    = frame_valid ? re_mem[rd_bank][i] : '0;
      complex_out[i] = frame_valid ? im_mem[rd_bank][i] : '0;
    end
  end

endmodule
